// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage.
// Contents: funct3 load/store encodings, FSM states, byte-enable patterns and the
// access-size decode used by both the lane logic and the misalignment check.
package mem_pkg;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Base byte-enable patterns, shifted into place by the low address bits
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_t;

    // Stores recognise only sb/sh as narrow; loads also treat lbu/lhu as narrow.
    // Every other encoding is a full-word access.
    function automatic acc_size_t access_size(input logic is_store, input logic [2:0] funct3);
        acc_size_t sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (funct3)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load lane select and sign/zero extension (purely combinational).
// Picks the byte or half addressed by addr_i out of the read word and extends it
// according to funct3; unknown encodings pass the whole word.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select by address, then extend by access type
    always_comb begin
        byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {24'h000000, byte_sel};
            F3_LHU:  data_o = {16'h0000, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, request/acknowledge data-memory port
// with byte strobes, load extension and the MEM/WB register.
// Optional build macro MISALIGN_CHECK_EN: when defined, misaligned half/word
// accesses are suppressed (no request, no stall) and flagged on MisalignW_o.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] ALUResultE_i,
    input  logic [DATA_WIDTH-1:0] WriteDataE_i,
    input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
    input  logic [4:0]            RdE_i,
    input  logic                  RegWriteE_i,
    input  logic                  MemWriteE_i,
    input  logic                  MemReadE_i,
    input  logic [1:0]            ResultSrcE_i,
    input  logic [2:0]            Funct3E_i,
    output logic                  DMemReq_o,
    output logic                  DMemWe_o,
    output logic [ADDR_WIDTH-1:0] DMemAddr_o,
    output logic [DATA_WIDTH-1:0] DMemWData_o,
    output logic [3:0]            DMemBe_o,
    input  logic                  DMemAck_i,
    input  logic [DATA_WIDTH-1:0] DMemRData_i,
    output logic                  StallM_o,
    output logic [DATA_WIDTH-1:0] ALUResultW_o,
    output logic [DATA_WIDTH-1:0] ReadDataW_o,
    output logic [DATA_WIDTH-1:0] PCPlus4W_o,
    output logic [4:0]            RdW_o,
    output logic                  RegWriteW_o,
    output logic [1:0]            ResultSrcW_o,
    output logic                  MisalignW_o
);

    // EX/MEM register
    logic [DATA_WIDTH-1:0] alu_m_q, alu_m_d;
    logic [DATA_WIDTH-1:0] wdata_m_q, wdata_m_d;
    logic [DATA_WIDTH-1:0] pc4_m_q, pc4_m_d;
    logic [4:0]            rd_m_q, rd_m_d;
    logic                  regwrite_m_q, regwrite_m_d;
    logic                  memwrite_m_q, memwrite_m_d;
    logic                  memread_m_q, memread_m_d;
    logic [1:0]            resultsrc_m_q, resultsrc_m_d;
    logic [2:0]            funct3_m_q, funct3_m_d;

    // MEM/WB register
    logic [DATA_WIDTH-1:0] alu_w_q, alu_w_d;
    logic [DATA_WIDTH-1:0] rdata_w_q, rdata_w_d;
    logic [DATA_WIDTH-1:0] pc4_w_q, pc4_w_d;
    logic [4:0]            rd_w_q, rd_w_d;
    logic                  regwrite_w_q, regwrite_w_d;
    logic [1:0]            resultsrc_w_q, resultsrc_w_d;
    logic                  misalign_w_q, misalign_w_d;

    mem_state_t state_q, state_d;

    acc_size_t             size;
    logic                  mem_op;
    logic                  misalign;
    logic                  pending;
    logic                  req;
    logic                  stall;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata_lanes;
    logic [DATA_WIDTH-1:0] load_val;

    load_extend u_load_extend (
        .rdata_i  (DMemRData_i),
        .addr_i   (alu_m_q[1:0]),
        .funct3_i (funct3_m_q),
        .data_o   (load_val)
    );

    // Access decode: size, misalignment, byte strobes and lane-replicated store data
    always_comb begin
        mem_op = memread_m_q | memwrite_m_q;
        size   = access_size(memwrite_m_q, funct3_m_q);
`ifdef MISALIGN_CHECK_EN
        misalign = mem_op & (((size == SZ_HALF) & alu_m_q[0]) |
                             ((size == SZ_WORD) & (|alu_m_q[1:0])));
`else
        misalign = 1'b0;
`endif
        pending = mem_op & ~misalign;
        case (size)
            SZ_BYTE: begin
                be          = BE_BYTE << alu_m_q[1:0];
                wdata_lanes = {4{wdata_m_q[7:0]}};
            end
            SZ_HALF: begin
                be          = BE_HALF << {alu_m_q[1], 1'b0};
                wdata_lanes = {2{wdata_m_q[15:0]}};
            end
            default: begin
                be          = BE_WORD;
                wdata_lanes = wdata_m_q;
            end
        endcase
    end

    // Request FSM: request is raised combinationally in IDLE and held through WAIT
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    req   = 1'b1;
                    stall = ~DMemAck_i;
                    if (!DMemAck_i) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                req   = 1'b1;
                stall = ~DMemAck_i;
                if (DMemAck_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // EX/MEM next value: capture execute outputs unless the stage is stalled
    always_comb begin
        alu_m_d       = alu_m_q;
        wdata_m_d     = wdata_m_q;
        pc4_m_d       = pc4_m_q;
        rd_m_d        = rd_m_q;
        regwrite_m_d  = regwrite_m_q;
        memwrite_m_d  = memwrite_m_q;
        memread_m_d   = memread_m_q;
        resultsrc_m_d = resultsrc_m_q;
        funct3_m_d    = funct3_m_q;
        if (!stall) begin
            alu_m_d       = ALUResultE_i;
            wdata_m_d     = WriteDataE_i;
            pc4_m_d       = PCPlus4E_i;
            rd_m_d        = RdE_i;
            regwrite_m_d  = RegWriteE_i;
            memwrite_m_d  = MemWriteE_i;
            memread_m_d   = MemReadE_i;
            resultsrc_m_d = ResultSrcE_i;
            funct3_m_d    = Funct3E_i;
        end
    end

    // MEM/WB next value: a bubble while stalled, otherwise the completed instruction
    always_comb begin
        alu_w_d       = '0;
        rdata_w_d     = '0;
        pc4_w_d       = '0;
        rd_w_d        = '0;
        regwrite_w_d  = 1'b0;
        resultsrc_w_d = '0;
        misalign_w_d  = 1'b0;
        if (!stall) begin
            alu_w_d       = alu_m_q;
            pc4_w_d       = pc4_m_q;
            rd_w_d        = rd_m_q;
            resultsrc_w_d = resultsrc_m_q;
            regwrite_w_d  = regwrite_m_q & ~misalign;
            misalign_w_d  = misalign;
            // a load paired with a store is a store, so no read data
            if (memread_m_q && !memwrite_m_q && !misalign) begin
                rdata_w_d = load_val;
            end
        end
    end

    // Pipeline and FSM state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            alu_m_q       <= '0;
            wdata_m_q     <= '0;
            pc4_m_q       <= '0;
            rd_m_q        <= '0;
            regwrite_m_q  <= 1'b0;
            memwrite_m_q  <= 1'b0;
            memread_m_q   <= 1'b0;
            resultsrc_m_q <= '0;
            funct3_m_q    <= '0;
            alu_w_q       <= '0;
            rdata_w_q     <= '0;
            pc4_w_q       <= '0;
            rd_w_q        <= '0;
            regwrite_w_q  <= 1'b0;
            resultsrc_w_q <= '0;
            misalign_w_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_m_q       <= alu_m_d;
            wdata_m_q     <= wdata_m_d;
            pc4_m_q       <= pc4_m_d;
            rd_m_q        <= rd_m_d;
            regwrite_m_q  <= regwrite_m_d;
            memwrite_m_q  <= memwrite_m_d;
            memread_m_q   <= memread_m_d;
            resultsrc_m_q <= resultsrc_m_d;
            funct3_m_q    <= funct3_m_d;
            alu_w_q       <= alu_w_d;
            rdata_w_q     <= rdata_w_d;
            pc4_w_q       <= pc4_w_d;
            rd_w_q        <= rd_w_d;
            regwrite_w_q  <= regwrite_w_d;
            resultsrc_w_q <= resultsrc_w_d;
            misalign_w_q  <= misalign_w_d;
        end
    end

    assign DMemReq_o    = req;
    assign DMemWe_o     = req & memwrite_m_q;
    assign DMemAddr_o   = req ? {alu_m_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign DMemWData_o  = req ? wdata_lanes : '0;
    assign DMemBe_o     = req ? be : BE_NONE;
    assign StallM_o     = stall;
    assign ALUResultW_o = alu_w_q;
    assign ReadDataW_o  = rdata_w_q;
    assign PCPlus4W_o   = pc4_w_q;
    assign RdW_o        = rd_w_q;
    assign RegWriteW_o  = regwrite_w_q;
    assign ResultSrcW_o = resultsrc_w_q;
    assign MisalignW_o  = misalign_w_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_mem_stage;

    logic        clk_i, rst_i;
    logic [31:0] ALUResultE_i, WriteDataE_i, PCPlus4E_i;
    logic [4:0]  RdE_i;
    logic        RegWriteE_i, MemWriteE_i, MemReadE_i;
    logic [1:0]  ResultSrcE_i;
    logic [2:0]  Funct3E_i;
    logic        DMemReq_o, DMemWe_o;
    logic [31:0] DMemAddr_o, DMemWData_o;
    logic [3:0]  DMemBe_o;
    logic        DMemAck_i;
    logic [31:0] DMemRData_i;
    logic        StallM_o;
    logic [31:0] ALUResultW_o, ReadDataW_o, PCPlus4W_o;
    logic [4:0]  RdW_o;
    logic        RegWriteW_o;
    logic [1:0]  ResultSrcW_o;
    logic        MisalignW_o;

    mem_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ALUResultE_i(ALUResultE_i), .WriteDataE_i(WriteDataE_i), .PCPlus4E_i(PCPlus4E_i),
        .RdE_i(RdE_i), .RegWriteE_i(RegWriteE_i), .MemWriteE_i(MemWriteE_i),
        .MemReadE_i(MemReadE_i), .ResultSrcE_i(ResultSrcE_i), .Funct3E_i(Funct3E_i),
        .DMemReq_o(DMemReq_o), .DMemWe_o(DMemWe_o), .DMemAddr_o(DMemAddr_o),
        .DMemWData_o(DMemWData_o), .DMemBe_o(DMemBe_o), .DMemAck_i(DMemAck_i),
        .DMemRData_i(DMemRData_i), .StallM_o(StallM_o), .ALUResultW_o(ALUResultW_o),
        .ReadDataW_o(ReadDataW_o), .PCPlus4W_o(PCPlus4W_o), .RdW_o(RdW_o),
        .RegWriteW_o(RegWriteW_o), .ResultSrcW_o(ResultSrcW_o), .MisalignW_o(MisalignW_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic        mr;
        logic [1:0]  rs;
        logic [2:0]  f3;
        int          dly;
        logic [31:0] rdat;
        int          id;
    } instr_t;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    instr_t nop, cand, m;
    int     waited;
    int     next_id;
    bit     rand_mode;
    bit     chk_en;
    logic        exp_req, exp_stall, exp_we;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;
    logic [31:0] w_alu, w_pc4, w_rdat;
    logic [4:0]  w_rd;
    logic [1:0]  w_rs;
    logic        w_rw, w_mis, w_bubble;
    int          w_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input int id, input logic mr, input logic mw, input logic [2:0] f3,
                                  input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] rdat,
                                  input int dly, input logic rw, input logic [4:0] rd);
        instr_t r;
        r.alu = alu; r.wd = wd; r.pc4 = alu + 32'h4; r.rd = rd; r.rw = rw; r.mw = mw; r.mr = mr;
        r.rs = 2'b01; r.f3 = f3; r.dly = dly; r.rdat = rdat; r.id = id;
        return r;
    endfunction

    // bytes touched by the access: 1, 2 or 4
    function automatic int model_size(input instr_t i);
        if (i.mw) return (i.f3 == 3'd0) ? 1 : (i.f3 == 3'd1) ? 2 : 4;
        return (i.f3[1:0] == 2'd0) ? 1 : (i.f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_mis(input instr_t i);
`ifdef MISALIGN_CHECK_EN
        int sz, a;
        if (!(i.mr || i.mw)) return 1'b0;
        sz = model_size(i);
        a  = int'(i.alu[1:0]);
        return ((sz == 2) && (a % 2 != 0)) || ((sz == 4) && (a != 0));
`else
        return (i.id < 0);
`endif
    endfunction

    function automatic logic [3:0] model_be(input instr_t i);
        int sz, a;
        sz = model_size(i);
        a  = int'(i.alu[1:0]);
        if (sz == 1) return 4'(1 << a);
        if (sz == 2) return (a >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wd(input instr_t i);
        int sz;
        sz = model_size(i);
        if (sz == 1) return {24'h0, i.wd[7:0]} * 32'h01010101;
        if (sz == 2) return {16'h0, i.wd[15:0]} * 32'h00010001;
        return i.wd;
    endfunction

    function automatic logic [31:0] model_ext(input logic [31:0] rdat, input logic [1:0] a, input logic [2:0] f3);
        logic [31:0] b, h;
        b = (rdat >> (8 * int'(a))) & 32'hFF;
        h = (rdat >> ((a >= 2'd2) ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            3'd5:    return h;
            default: return rdat;
        endcase
    endfunction

    task automatic rand_instr(output instr_t r);
        int op;
        logic [31:0] t;
        op = $urandom_range(0, 9);
        r.alu = $urandom; r.wd = $urandom; r.pc4 = $urandom; r.rdat = $urandom;
        t = $urandom;
        r.rd = t[4:0]; r.rs = t[6:5]; r.f3 = t[9:7]; r.rw = t[10];
        r.mr = (op >= 3 && op < 6) || op == 9;
        r.mw = (op >= 6);
`ifndef MISALIGN_CHECK_EN
        if (r.mr && !r.mw && r.f3[1:0] == 2'b01) r.alu[0] = 1'b0;
`endif
        r.dly = $urandom_range(0, 3);
        r.id  = next_id;
        next_id++;
    endtask

    // drive this cycle's inputs and derive the expected combinational outputs
    task automatic begin_cycle();
        logic pend;
        pend = (m.mr || m.mw) && !model_mis(m);
        DMemAck_i   = pend ? (waited >= m.dly) : ($urandom_range(0, 1) == 1);
        DMemRData_i = pend ? m.rdat : $urandom;
        ALUResultE_i = cand.alu; WriteDataE_i = cand.wd; PCPlus4E_i = cand.pc4;
        RdE_i = cand.rd; RegWriteE_i = cand.rw; MemWriteE_i = cand.mw; MemReadE_i = cand.mr;
        ResultSrcE_i = cand.rs; Funct3E_i = cand.f3;
        exp_req   = pend;
        exp_stall = pend && !DMemAck_i;
        exp_we    = pend && m.mw;
        exp_addr  = {m.alu[31:2], 2'b00};
        exp_be    = model_be(m);
        exp_wd    = model_wd(m);
    endtask

    // advance the model across the clock edge
    task automatic end_cycle();
        @(posedge clk_i);
        if (exp_stall) begin
            waited++;
            w_bubble = 1'b1; w_rw = 1'b0; w_mis = 1'b0; w_id = -1;
        end else begin
            w_mis = model_mis(m);
            w_bubble = 1'b0; w_id = m.id;
            w_alu = m.alu; w_pc4 = m.pc4; w_rd = m.rd; w_rs = m.rs;
            w_rw = m.rw && !w_mis;
            w_rdat = (m.mr && !m.mw && !w_mis) ? model_ext(m.rdat, m.alu[1:0], m.f3) : 32'h0;
            m = cand;
            waited = 0;
            if (rand_mode) rand_instr(cand);
            else cand = nop;
        end
        #1;
    endtask

    task automatic model_reset();
        m = nop; waited = 0;
        w_alu = 0; w_pc4 = 0; w_rdat = 0; w_rd = 0; w_rs = 0;
        w_rw = 0; w_mis = 0; w_bubble = 0; w_id = 0;
    endtask

    // every-cycle comparison against the model
    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("req", 32'(DMemReq_o), 32'(exp_req));
            chk("stall", 32'(StallM_o), 32'(exp_stall));
            if (exp_req) begin
                chk("we", 32'(DMemWe_o), 32'(exp_we));
                chk("addr", DMemAddr_o, exp_addr);
                chk("be", 32'(DMemBe_o), 32'(exp_be));
                if (exp_we) chk("wdata", DMemWData_o, exp_wd);
            end
            chk("regwrite_w", 32'(RegWriteW_o), 32'(w_rw));
            chk("misalign_w", 32'(MisalignW_o), 32'(w_mis));
            if (!w_bubble) begin
                chk("alu_w", ALUResultW_o, w_alu);
                chk("pc4_w", PCPlus4W_o, w_pc4);
                chk("rd_w", 32'(RdW_o), 32'(w_rd));
                chk("rs_w", 32'(ResultSrcW_o), 32'(w_rs));
                chk("rdata_w", ReadDataW_o, w_rdat);
            end
        end
    end

    task automatic run_dir(input string nm, input instr_t i, input int ex_stalls, input int ex_reqs,
                           input logic [31:0] l_addr, input logic [3:0] l_be, input logic [31:0] l_wd,
                           input logic [31:0] l_rd, input logic l_rw, input logic l_mis);
        int stalls, reqs;
        bit done;
        stalls = 0; reqs = 0; done = 0;
        cand = i;
        begin_cycle(); end_cycle();
        for (int k = 0; k < 20 && !done; k++) begin
            begin_cycle();
            #1;
            if (DMemReq_o) begin
                reqs++;
                chk({nm, "_addr"}, DMemAddr_o, l_addr);
                chk({nm, "_be"}, 32'(DMemBe_o), 32'(l_be));
                if (i.mw) chk({nm, "_wdata"}, DMemWData_o, l_wd);
            end
            if (StallM_o) stalls++;
            end_cycle();
            if (w_id == i.id) begin
                done = 1;
                chk({nm, "_rdata_w"}, ReadDataW_o, l_rd);
                chk({nm, "_regwrite_w"}, 32'(RegWriteW_o), 32'(l_rw));
                chk({nm, "_misalign_w"}, 32'(MisalignW_o), 32'(l_mis));
            end
        end
        if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
        chk({nm, "_stall_cycles"}, 32'(stalls), 32'(ex_stalls));
        chk({nm, "_req_cycles"}, 32'(reqs), 32'(ex_reqs));
    endtask

    initial begin
        instr_t add_i;
        nop = mk(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 5'd0);
        nop.pc4 = 32'h0; nop.rs = 2'b00;
        cand = nop; next_id = 100; rand_mode = 0; chk_en = 0;
        model_reset();
        rst_i = 1'b1; DMemAck_i = 0; DMemRData_i = 0;
        ALUResultE_i = 0; WriteDataE_i = 0; PCPlus4E_i = 0; RdE_i = 0; RegWriteE_i = 0;
        MemWriteE_i = 0; MemReadE_i = 0; ResultSrcE_i = 0; Funct3E_i = 0;
        #8;
        chk("rst_req", 32'(DMemReq_o), 32'd0);
        chk("rst_stall", 32'(StallM_o), 32'd0);
        chk("rst_regwrite_w", 32'(RegWriteW_o), 32'd0);
        chk("rst_alu_w", ALUResultW_o, 32'd0);
        chk("rst_rdata_w", ReadDataW_o, 32'd0);
        chk("rst_misalign_w", 32'(MisalignW_o), 32'd0);

        // model pins
        chk("pin_lb", model_ext(32'h80123456, 2'd3, 3'd0), 32'hFFFFFF80);
        chk("pin_lhu", model_ext(32'h80123456, 2'd2, 3'd5), 32'h00008012);

        rst_i = 1'b0;
        begin_cycle();
        chk_en = 1;
        end_cycle();

        run_dir("sw", mk(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 5'd0),
                0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        run_dir("lb", mk(2, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 3, 1, 5'd5),
                3, 4, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0);
        run_dir("lbu", mk(3, 1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1, 1, 5'd6),
                1, 2, 32'h100, 4'b1000, 32'h0, 32'h00000080, 1'b1, 1'b0);
        run_dir("lhu", mk(4, 1, 0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0, 1, 5'd7),
                0, 1, 32'h100, 4'b1100, 32'h0, 32'h00008012, 1'b1, 1'b0);
        run_dir("lh", mk(5, 1, 0, 3'b001, 32'h102, 32'h0, 32'h80123456, 2, 1, 5'd8),
                2, 3, 32'h100, 4'b1100, 32'h0, 32'hFFFF8012, 1'b1, 1'b0);
        run_dir("sh", mk(6, 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 0, 5'd0),
                0, 1, 32'h100, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 1'b0);
`ifdef MISALIGN_CHECK_EN
        run_dir("lw_mis", mk(7, 1, 0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 1, 1, 5'd9),
                0, 0, 32'h100, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1);
`else
        run_dir("lw_mis", mk(7, 1, 0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 1, 1, 5'd9),
                1, 2, 32'h100, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
`endif

        // reset while waiting for an acknowledge
        add_i = mk(8, 0, 0, 3'b000, 32'h12345678, 32'h0, 32'h0, 0, 1, 5'd7);
        cand = mk(9, 1, 0, 3'b010, 32'h200, 32'h0, 32'h11111111, 10, 1, 5'd3);
        begin_cycle(); end_cycle();
        cand = add_i;
        begin_cycle(); end_cycle();
        begin_cycle();
        #2;
        rst_i = 1'b1;
        #1;
        chk_en = 0;
        chk("arst_req", 32'(DMemReq_o), 32'd0);
        chk("arst_stall", 32'(StallM_o), 32'd0);
        chk("arst_regwrite_w", 32'(RegWriteW_o), 32'd0);
        chk("arst_alu_w", ALUResultW_o, 32'd0);
        chk("arst_rdata_w", ReadDataW_o, 32'd0);
        chk("arst_pc4_w", PCPlus4W_o, 32'd0);
        chk("arst_rd_w", 32'(RdW_o), 32'd0);
        chk("arst_rs_w", 32'(ResultSrcW_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        begin_cycle();
        chk_en = 1;
        end_cycle();
        begin_cycle(); end_cycle();
        chk("post_rst_add_alu", ALUResultW_o, 32'h12345678);
        chk("post_rst_add_rd", 32'(RdW_o), 32'd7);
        chk("post_rst_add_rw", 32'(RegWriteW_o), 32'd1);

        // randomized traffic
        rand_mode = 1;
        rand_instr(cand);
        for (int c = 0; c < 800; c++) begin
            begin_cycle();
            end_cycle();
        end
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
